// File: rtl/prime_pkg.sv
// Shared types and constants for the prime_fetch consumer path.
package prime_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_STREAM, ST_FIN} state_e;

  localparam int DEF_WIDTH = 512;

  localparam logic [1:0] P_IDX = 2'd0;
  localparam logic [1:0] Q_IDX = 2'd1;
  localparam logic [1:0] R_IDX = 2'd2;
  localparam logic [1:0] S_IDX = 2'd3;
endpackage

// File: rtl/prime_word_serializer.sv
// Holds captured p/q/r/s and presents them word by word on a stall-safe stream register.
module prime_word_serializer
  import prime_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DATA_W = 32
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_load,
  input  logic [3:0][WIDTH/DATA_W-1:0][DATA_W-1:0]     i_data,
  input  logic                                         i_tready,
  output logic [DATA_W-1:0]                            o_tdata,
  output logic                                         o_tvalid,
  output logic                                         o_tlast,
  output logic [1:0]                                   o_tid,
  output logic                                         o_last_acc
);
  localparam int WORDS = WIDTH / DATA_W;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCW-1:0] LAST_W = WCW'(WORDS - 1);

  // Buffer is viewed as [prime][word] so word select is plain indexing.
  logic [3:0][WORDS-1:0][DATA_W-1:0] r_buf;
  logic [WCW-1:0]    r_widx, w_widx_nxt;
  logic [1:0]        r_pidx, w_pidx_nxt;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid, r_tlast;
  logic [1:0]        r_tid;
  logic              w_hs;

  assign w_hs       = r_tvalid & i_tready;
  assign o_last_acc = w_hs & r_tlast & (r_tid == S_IDX);
  assign o_tdata    = r_tdata;
  assign o_tvalid   = r_tvalid;
  assign o_tlast    = r_tlast;
  assign o_tid      = r_tid;

  always_comb begin
    w_widx_nxt = r_widx + 1'b1;
    w_pidx_nxt = r_pidx;
    if (r_widx == LAST_W) begin
      w_widx_nxt = '0;
      w_pidx_nxt = r_pidx + 1'b1;
    end
  end

  // Output register only moves on load or handshake, so it holds while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_widx   <= '0;
      r_pidx   <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tid    <= '0;
    end else if (i_load) begin
      r_buf    <= i_data;
      r_widx   <= '0;
      r_pidx   <= P_IDX;
      r_tdata  <= i_data[P_IDX][0];
      r_tid    <= P_IDX;
      r_tlast  <= (LAST_W == '0);
      r_tvalid <= 1'b1;
    end else if (w_hs) begin
      if (o_last_acc) begin
        r_tvalid <= 1'b0;
      end else begin
        r_widx  <= w_widx_nxt;
        r_pidx  <= w_pidx_nxt;
        r_tdata <= r_buf[w_pidx_nxt][w_widx_nxt];
        r_tid   <= w_pidx_nxt;
        r_tlast <= (w_widx_nxt == LAST_W);
      end
    end
  end
endmodule

// File: rtl/prime_fetch.sv
// Requests one p/q/r/s set from prime_feed, then streams it out as DATA_W words.
module prime_fetch
  import prime_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              next,
  input  logic              pqrs_ready,
  input  logic [WIDTH-1:0]  p,
  input  logic [WIDTH-1:0]  q,
  input  logic [WIDTH-1:0]  r,
  input  logic [WIDTH-1:0]  s,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [1:0]        m_tid
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_done, r_error, r_next;
  logic          w_load, w_timeout, w_last_acc;

  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;
  assign next  = r_next;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_REQ;
      ST_REQ:    w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (pqrs_ready) begin
          w_load      = 1'b1;
          w_state_nxt = ST_STREAM;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: if (w_last_acc) w_state_nxt = ST_FIN;
      ST_FIN:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_next  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_FIN);
      r_next  <= (w_state_nxt == ST_REQ);
      if (r_state == ST_REQ)
        r_cnt <= '0;
      else if (r_state == ST_WAIT && !pqrs_ready && !w_timeout)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_IDLE && start)
        r_error <= 1'b0;
      else if (w_timeout)
        r_error <= 1'b1;
    end
  end

  prime_word_serializer #(.WIDTH(WIDTH), .DATA_W(DATA_W)) u_ser (
    .i_clk      (aclk),
    .i_rst      (areset),
    .i_load     (w_load),
    .i_data     ({s, r, q, p}),
    .i_tready   (m_tready),
    .o_tdata    (m_tdata),
    .o_tvalid   (m_tvalid),
    .o_tlast    (m_tlast),
    .o_tid      (m_tid),
    .o_last_acc (w_last_acc)
  );
endmodule

// File: tb/tb_prime_fetch.sv
// Scoreboard bench for prime_fetch: WIDTH=64, DATA_W=16, TIMEOUT=8.
module tb_prime_fetch;
  localparam int W  = 64;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error, next;
  logic          pqrs_ready = 1'b0;
  logic [W-1:0]  p = '0, q = '0, r = '0, s = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b1;
  logic [1:0]    m_tid;

  prime_fetch #(.WIDTH(W), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset), .start(start), .busy(busy), .done(done),
    .error(error), .next(next), .pqrs_ready(pqrs_ready), .p(p), .q(q), .r(r), .s(s),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tid(m_tid)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_fail = 0;
  int hs_cnt = 0, next_cnt = 0, done_cnt = 0, valid_cnt = 0, stall_cnt = 0;
  logic [18:0] sb[$];
  logic        rdy_mode = 1'b0;
  logic        rdy_level = 1'b1;

  // Drives m_tready a little after each edge; pattern mode gives 1-0-0-1 backpressure.
  task automatic ready_driver();
    logic [3:0] pat = 4'b1001;
    int ph = 0;
    forever begin
      @(posedge aclk); #2;
      m_tready = rdy_mode ? pat[ph] : rdy_level;
      ph = (ph + 1) % 4;
    end
  endtask

  task automatic monitor();
    logic        prev_stall = 1'b0;
    logic [18:0] prev_word = '0, got, exp;
    forever begin
      @(negedge aclk);
      got = {m_tid, m_tlast, m_tdata};
      if (areset) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          stall_cnt++;
          n_chk++;
          if (!m_tvalid || got !== prev_word) begin
            n_fail++;
            $display("FAIL stall_hold: got %h valid %b, held %h", got, m_tvalid, prev_word);
          end
        end
        if (m_tvalid && m_tready) begin
          hs_cnt++;
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: got %h, no word expected", got);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL sb_word: got %h, expected %h", got, exp);
            end
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_word  = got;
        if (next) next_cnt++;
        if (done) done_cnt++;
        if (m_tvalid) valid_cnt++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge aclk); #1;
  endtask

  task automatic push_expected(input logic [W-1:0] pp, qq, rr, ss);
    logic [W-1:0] pr[4];
    logic [1:0]   tid;
    pr = '{pp, qq, rr, ss};
    for (int t = 0; t < 4; t++)
      for (int w = 0; w < W/DW; w++) begin
        tid = t[1:0];
        sb.push_back({tid, (w == W/DW - 1), pr[t][w*DW +: DW]});
      end
  endtask

  // start at cycle 0, pqrs_ready at cycle 2+wt; lat = cycles from pqrs_ready to done (-1 if none).
  task automatic do_fetch(input int wt, input logic [W-1:0] pp, qq, rr, ss,
                          input logic inj, output int lat);
    start = 1'b1; cyc();
    start = 1'b0;
    repeat (1 + wt) cyc();
    pqrs_ready = 1'b1; p = pp; q = qq; r = rr; s = ss;
    push_expected(pp, qq, rr, ss);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (i == 1) begin
        pqrs_ready = 1'b0; p = '0; q = '0; r = '0; s = '0;
      end
      start = inj && (i == 5);
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    n_chk++;
    if ({busy, done, error, next, m_tvalid, m_tlast, m_tid, m_tdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b %b %b %b %b %b %h %h, required all zero",
               busy, done, error, next, m_tvalid, m_tlast, m_tid, m_tdata);
    end
    areset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    int lat, n0 = next_cnt, d0 = done_cnt, h0 = hs_cnt;
    do_fetch(2, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008,
             64'h0009_000a_000b_000c, 64'h000d_000e_000f_0010, 1'b0, lat);
    n_chk++;
    if (lat !== 17) begin n_fail++; $display("FAIL basic_done_latency: got %0d, required 17", lat); end
    n_chk++;
    if (next_cnt - n0 !== 1) begin n_fail++; $display("FAIL basic_next_count: got %0d, required 1", next_cnt - n0); end
    n_chk++;
    if (done_cnt - d0 !== 1 || hs_cnt - h0 !== 16) begin
      n_fail++; $display("FAIL basic_counts: done %0d hs %0d, required 1 16", done_cnt - d0, hs_cnt - h0);
    end
  endtask

  task automatic test_backpressure();
    int lat, h0 = hs_cnt, s0 = stall_cnt;
    rdy_mode = 1'b1;
    do_fetch(1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
             64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0123, 1'b0, lat);
    rdy_mode = 1'b0;
    n_chk++;
    if (lat < 0) begin n_fail++; $display("FAIL bp_done: no done within bound, got %0d", lat); end
    n_chk++;
    if (hs_cnt - h0 !== 16) begin n_fail++; $display("FAIL bp_handshakes: got %0d, required 16", hs_cnt - h0); end
    n_chk++;
    if (stall_cnt - s0 < 8) begin n_fail++; $display("FAIL bp_stalls: got %0d, required >= 8", stall_cnt - s0); end
  endtask

  task automatic test_timeout();
    int lat, v0 = valid_cnt;
    start = 1'b1; cyc();
    start = 1'b0;
    repeat (8) cyc();
    n_chk++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_early: error %b busy %b, required 0 1", error, busy);
    end
    cyc();
    n_chk++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_error: error %b busy %b, required 1 0", error, busy);
    end
    n_chk++;
    if (valid_cnt !== v0) begin n_fail++; $display("FAIL to_no_valid: got %0d valid cycles, required 0", valid_cnt - v0); end
    do_fetch(1, 64'hcafe_f00d_dead_beef, 64'h0123_4567_89ab_cdef,
             64'hfedc_ba98_7654_3210, 64'h0f0f_f0f0_a5a5_5a5a, 1'b0, lat);
    n_chk++;
    if (lat !== 17 || error !== 1'b0) begin
      n_fail++; $display("FAIL to_recover: lat %0d error %b, required 17 0", lat, error);
    end
  endtask

  task automatic test_zero_wait();
    int lat;
    logic [W-1:0] rp = {$urandom, $urandom}, rq = {$urandom, $urandom};
    logic [W-1:0] rr = {$urandom, $urandom}, rs = {$urandom, $urandom};
    do_fetch(0, rp, rq, rr, rs, 1'b0, lat);
    n_chk++;
    if (lat !== 17) begin n_fail++; $display("FAIL zw_latency: got %0d, required 17", lat); end
  endtask

  task automatic test_reset_mid();
    int lat, h0 = hs_cnt, d0 = done_cnt;
    start = 1'b1; cyc();
    start = 1'b0; cyc();
    pqrs_ready = 1'b1;
    p = 64'h0a0a_0b0b_0c0c_0d0d; q = 64'h1; r = 64'h2; s = 64'h3;
    push_expected(p, q, r, s);
    cyc();
    pqrs_ready = 1'b0;
    for (int i = 0; i < 50 && hs_cnt - h0 < 6; i++) cyc();
    areset = 1'b1; rdy_level = 1'b0;
    cyc();
    n_chk++;
    if ({busy, done, error, next, m_tvalid, m_tlast, m_tid, m_tdata} !== '0) begin
      n_fail++; $display("FAIL rst_mid_state: got %b %b %b %b %b %b %h %h, required all zero",
                         busy, done, error, next, m_tvalid, m_tlast, m_tid, m_tdata);
    end
    areset = 1'b0; rdy_level = 1'b1;
    sb.delete();
    cyc();
    do_fetch(1, 64'h7777_6666_5555_4444, 64'h3333_2222_1111_0000,
             64'h0102_0304_0506_0708, 64'h1020_3040_5060_7080, 1'b0, lat);
    n_chk++;
    if (done_cnt - d0 !== 1 || lat !== 17) begin
      n_fail++; $display("FAIL rst_mid_done: done %0d lat %0d, required 1 17", done_cnt - d0, lat);
    end
  endtask

  task automatic test_ignored();
    int lat, n0 = next_cnt, d0 = done_cnt, v0 = valid_cnt;
    pqrs_ready = 1'b1; cyc();
    pqrs_ready = 1'b0; cyc();
    n_chk++;
    if (busy !== 1'b0 || next_cnt !== n0 || valid_cnt !== v0) begin
      n_fail++; $display("FAIL ign_idle_ready: busy %b next %0d valid %0d, required 0 0 0",
                         busy, next_cnt - n0, valid_cnt - v0);
    end
    do_fetch(2, 64'haaaa_bbbb_cccc_dddd, 64'h1234_5678_9abc_def0,
             64'h0fed_cba9_8765_4321, 64'h0000_ffff_0000_ffff, 1'b1, lat);
    repeat (4) cyc();
    n_chk++;
    if (next_cnt - n0 !== 1 || done_cnt - d0 !== 1 || lat !== 17 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ign_stream_start: next %0d done %0d lat %0d busy %b, required 1 1 17 0",
                         next_cnt - n0, done_cnt - d0, lat, busy);
    end
  endtask

  initial begin
    fork
      monitor();
      ready_driver();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_zero_wait();
    test_reset_mid();
    test_ignored();
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d words never seen, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
